// File: rtl/bpu_bias_pkg.sv
// Shared types and helpers for the bias-table update controller.
package bpu_bias_pkg;

  localparam int unsigned DEF_TABLE_DEPTH = 1024;
  localparam int unsigned IDX_W = $clog2(DEF_TABLE_DEPTH);
  localparam int unsigned W_W = 2;
  localparam logic [W_W-1:0] W_MAX = 2'd3;
  localparam logic [W_W-1:0] W_MIN = 2'd0;

  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic             taken;
  } upd_entry_t;

  typedef enum logic [2:0] {INIT, IDLE, RD, WT, WR} ctrl_state_t;

  function automatic logic [W_W-1:0] sat_update(input logic [W_W-1:0] weight,
                                               input logic taken);
    logic [W_W-1:0] w_res;
    if (taken) w_res = (weight == W_MAX) ? weight : weight + 1'b1;
    else       w_res = (weight == W_MIN) ? weight : weight - 1'b1;
    return w_res;
  endfunction

endpackage

// File: rtl/bias_upd_fifo.sv
// Small synchronous queue of pending bias updates; pointers carry an extra wrap bit.
module bias_upd_fifo
  import bpu_bias_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_push,
  input  upd_entry_t i_data,
  input  logic       i_pop,
  output upd_entry_t o_head,
  output logic       o_full,
  output logic       o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  upd_entry_t  r_mem [DEPTH];
  logic        w_push;
  logic        w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/bias_update_ctrl.sv
// Bias-table training sequencer: init sweep, then queued read-modify-write updates
// sharing the single table read port with fetch.
//   state | meaning
//   INIT  | sweeping every entry to INIT_WEIGHT
//   IDLE  | waiting for a queued update
//   RD    | update competing with fetch for the read port
//   WT    | table read in flight, weight captured at end of cycle
//   WR    | saturated weight written back
module bias_update_ctrl
  import bpu_bias_pkg::*;
#(
  parameter int unsigned     TABLE_DEPTH  = DEF_TABLE_DEPTH,
  parameter int unsigned     FIFO_DEPTH   = 4,
  parameter int unsigned     STARVE_LIMIT = 8,
  parameter logic [W_W-1:0]  INIT_WEIGHT  = 2'b01
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_upd_valid,
  output logic             o_upd_ready,
  input  logic [IDX_W-1:0] i_upd_index,
  input  logic             i_upd_taken,
  input  logic             i_pred_req,
  input  logic [IDX_W-1:0] i_pred_index,
  output logic             o_pred_stall,
  output logic [IDX_W-1:0] o_tbl_index,
  input  logic [W_W-1:0]   i_tbl_weight,
  output logic             o_tbl_wr_en,
  output logic [IDX_W-1:0] o_tbl_wr_index,
  output logic [W_W-1:0]   o_tbl_wr_weight,
  output logic             o_init_done
);

  localparam int unsigned      STV_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [IDX_W-1:0] SWEEP_LAST = IDX_W'(TABLE_DEPTH - 1);
  localparam logic [STV_W-1:0] STARVE_TC  = STV_W'(STARVE_LIMIT);

  ctrl_state_t      r_state, w_state_nxt;
  logic [IDX_W-1:0] r_sweep, w_sweep_nxt;
  logic [STV_W-1:0] r_starve, w_starve_nxt;
  upd_entry_t       r_inflight, w_inflight_nxt;
  logic [W_W-1:0]   r_weight, w_weight_nxt;
  logic             r_pred_stall, w_pred_stall_nxt;
  logic [IDX_W-1:0] r_tbl_index, w_tbl_index_nxt;
  logic             r_wr_en, w_wr_en_nxt;
  logic [IDX_W-1:0] r_wr_index, w_wr_index_nxt;
  logic [W_W-1:0]   r_wr_weight, w_wr_weight_nxt;
  logic             r_init_done, w_init_done_nxt;

  upd_entry_t       w_upd_in;
  upd_entry_t       w_head;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;

  assign w_upd_in.index = i_upd_index;
  assign w_upd_in.taken = i_upd_taken;
  assign o_upd_ready    = r_init_done & ~w_full;
  assign w_push         = i_upd_valid & o_upd_ready;

  bias_upd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_data  (w_upd_in),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_sweep_nxt      = r_sweep;
    w_starve_nxt     = r_starve;
    w_inflight_nxt   = r_inflight;
    w_weight_nxt     = r_weight;
    w_pred_stall_nxt = 1'b0;
    w_tbl_index_nxt  = i_pred_index;
    w_wr_en_nxt      = 1'b0;
    w_wr_index_nxt   = r_wr_index;
    w_wr_weight_nxt  = r_wr_weight;
    w_init_done_nxt  = 1'b1;
    w_pop            = 1'b0;

    case (r_state)
      INIT: begin
        w_pred_stall_nxt = 1'b1;
        w_tbl_index_nxt  = r_tbl_index;
        w_init_done_nxt  = 1'b0;
        w_wr_en_nxt      = 1'b1;
        w_wr_index_nxt   = r_sweep;
        w_wr_weight_nxt  = INIT_WEIGHT;
        w_sweep_nxt      = r_sweep + 1'b1;
        if (r_sweep == SWEEP_LAST) w_state_nxt = IDLE;
      end
      IDLE: begin
        if (!w_empty) begin
          w_pop          = 1'b1;
          w_inflight_nxt = w_head;
          w_state_nxt    = RD;
        end
      end
      RD: begin
        // Fetch wins until the update has lost STARVE_LIMIT times in a row.
        if (!i_pred_req || (r_starve == STARVE_TC)) begin
          w_tbl_index_nxt  = r_inflight.index;
          w_pred_stall_nxt = i_pred_req;
          w_starve_nxt     = '0;
          w_state_nxt      = WT;
        end else begin
          w_starve_nxt = r_starve + 1'b1;
        end
      end
      WT: begin
        w_weight_nxt = i_tbl_weight;
        w_state_nxt  = WR;
      end
      WR: begin
        w_wr_en_nxt     = 1'b1;
        w_wr_index_nxt  = r_inflight.index;
        w_wr_weight_nxt = sat_update(r_weight, r_inflight.taken);
        if (!w_empty) begin
          w_pop          = 1'b1;
          w_inflight_nxt = w_head;
          w_state_nxt    = RD;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = INIT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= INIT;
      r_sweep      <= '0;
      r_starve     <= '0;
      r_inflight   <= '0;
      r_weight     <= '0;
      r_pred_stall <= 1'b1;
      r_tbl_index  <= '0;
      r_wr_en      <= 1'b0;
      r_wr_index   <= '0;
      r_wr_weight  <= '0;
      r_init_done  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sweep      <= w_sweep_nxt;
      r_starve     <= w_starve_nxt;
      r_inflight   <= w_inflight_nxt;
      r_weight     <= w_weight_nxt;
      r_pred_stall <= w_pred_stall_nxt;
      r_tbl_index  <= w_tbl_index_nxt;
      r_wr_en      <= w_wr_en_nxt;
      r_wr_index   <= w_wr_index_nxt;
      r_wr_weight  <= w_wr_weight_nxt;
      r_init_done  <= w_init_done_nxt;
    end
  end

  assign o_pred_stall    = r_pred_stall;
  assign o_tbl_index     = r_tbl_index;
  assign o_tbl_wr_en     = r_wr_en;
  assign o_tbl_wr_index  = r_wr_index;
  assign o_tbl_wr_weight = r_wr_weight;
  assign o_init_done     = r_init_done;

endmodule

// File: tb/tb_bias_update_ctrl.sv
// Randomised + directed bench for bias_update_ctrl against a queue-based behavioural model.
module tb_bias_update_ctrl;

  localparam int DEPTH  = 1024;
  localparam int FIFO_D = 4;
  localparam int STARVE = 8;
  localparam int INIT_W = 1;

  logic       clk;
  logic       rst_n;
  logic       upd_valid, upd_ready, upd_taken;
  logic       pred_req, pred_stall;
  logic [9:0] upd_index, pred_index, tbl_index, tbl_wr_index;
  logic [1:0] tbl_weight, tbl_wr_weight;
  logic       tbl_wr_en, init_done;

  logic [1:0] tbl_mem [DEPTH];
  assign tbl_weight = tbl_mem[tbl_index];

  bias_update_ctrl dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_upd_valid     (upd_valid),
    .o_upd_ready     (upd_ready),
    .i_upd_index     (upd_index),
    .i_upd_taken     (upd_taken),
    .i_pred_req      (pred_req),
    .i_pred_index    (pred_index),
    .o_pred_stall    (pred_stall),
    .o_tbl_index     (tbl_index),
    .i_tbl_weight    (tbl_weight),
    .o_tbl_wr_en     (tbl_wr_en),
    .o_tbl_wr_index  (tbl_wr_index),
    .o_tbl_wr_weight (tbl_wr_weight),
    .o_init_done     (init_done)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc;
  bit chk_en = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Table: random power-up contents, written on the falling edge.
  initial begin
    for (int i = 0; i < DEPTH; i++) tbl_mem[i] = 2'($urandom);
    forever begin
      @(negedge clk);
      if (tbl_wr_en) tbl_mem[tbl_wr_index] = tbl_wr_weight;
    end
  end

  // ---------------- behavioural model ----------------
  typedef struct {int idx; int tk;} job_t;
  job_t m_q[$];
  job_t m_job;
  int   m_mem [DEPTH];
  int   m_sweep, m_starve, m_wait;
  bit   m_busy, m_granted;
  int   e_ready, e_stall, e_tidx, e_wen, e_widx, e_ww, e_done;

  task automatic m_reset();
    m_q.delete();
    m_sweep = 0; m_starve = 0; m_wait = 0; m_busy = 0; m_granted = 0;
    e_ready = 0; e_stall = 1; e_tidx = 0; e_wen = 0; e_widx = 0; e_ww = 0; e_done = 0;
  endtask

  task automatic m_step();
    bit   acc;
    job_t in_e;
    int   w, nw;
    acc     = upd_valid && (e_ready != 0);
    in_e.idx = int'(upd_index);
    in_e.tk  = int'(upd_taken);
    e_wen = 0;
    if (m_sweep < DEPTH) begin
      e_wen = 1; e_widx = m_sweep; e_ww = INIT_W;
      m_mem[m_sweep] = INIT_W;
      m_sweep++;
    end else begin
      e_done = 1; e_stall = 0; e_tidx = int'(pred_index);
      if (!m_busy) begin
        if (m_q.size() != 0) begin m_job = m_q.pop_front(); m_busy = 1; m_granted = 0; end
      end else if (!m_granted) begin
        if (!pred_req || m_starve == STARVE) begin
          e_tidx = m_job.idx; e_stall = int'(pred_req);
          m_starve = 0; m_granted = 1; m_wait = 2;
        end else begin
          m_starve++;
        end
      end else begin
        m_wait--;
        if (m_wait == 0) begin
          w = m_mem[m_job.idx];
          if (m_job.tk != 0) nw = (w == 3) ? 3 : w + 1;
          else               nw = (w == 0) ? 0 : w - 1;
          m_mem[m_job.idx] = nw;
          e_wen = 1; e_widx = m_job.idx; e_ww = nw;
          m_busy = 0;
          if (m_q.size() != 0) begin m_job = m_q.pop_front(); m_busy = 1; m_granted = 0; end
        end
      end
    end
    if (acc) m_q.push_back(in_e);
    e_ready = (e_done != 0 && m_q.size() < FIFO_D) ? 1 : 0;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  // ---------------- per-cycle compare + write log ----------------
  typedef struct {int idx; int w; int cyc;} wr_t;
  wr_t wlog[$];
  wr_t wtmp;

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("upd_ready",  int'(upd_ready),  e_ready);
        chk("pred_stall", int'(pred_stall), e_stall);
        chk("tbl_index",  int'(tbl_index),  e_tidx);
        chk("tbl_wr_en",  int'(tbl_wr_en),  e_wen);
        chk("init_done",  int'(init_done),  e_done);
        if (e_wen != 0) begin
          chk("tbl_wr_index",  int'(tbl_wr_index),  e_widx);
          chk("tbl_wr_weight", int'(tbl_wr_weight), e_ww);
        end
      end
      if (tbl_wr_en) begin
        wtmp.idx = int'(tbl_wr_index); wtmp.w = int'(tbl_wr_weight); wtmp.cyc = cyc;
        wlog.push_back(wtmp);
      end
    end
  end

  // ---------------- directed helpers ----------------
  int last_push_cyc;

  task automatic push(input int idx, input int tk);
    int g;
    g = 0;
    @(negedge clk);
    while (!upd_ready && g < 300) begin @(negedge clk); g++; end
    chk("push_ready_timeout", int'(upd_ready), 1);
    upd_valid = 1'b1; upd_index = 10'(idx); upd_taken = tk[0];
    @(negedge clk);
    upd_valid = 1'b0;
    last_push_cyc = cyc;
  endtask

  task automatic wait_writes(input int n, input int budget);
    int g;
    g = 0;
    while (wlog.size() < n && g < budget) begin @(negedge clk); g++; end
    chk("write_timeout", (wlog.size() >= n) ? 1 : 0, 1);
  endtask

  task automatic wait_init();
    int g;
    g = 0;
    while (!init_done && g < 1200) begin @(negedge clk); g++; end
    chk("init_timeout", int'(init_done), 1);
  endtask

  int  done_cyc, ones, sent, guard;
  bit  saw_low;
  int  exp_sat7 [3] = '{2, 3, 3};

  initial begin
    rst_n = 1'b1; upd_valid = 1'b0; upd_index = '0; upd_taken = 1'b0;
    pred_req = 1'b0; pred_index = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_upd_ready",  int'(upd_ready), 0);
    chk("rst_pred_stall", int'(pred_stall), 1);
    chk("rst_tbl_index",  int'(tbl_index), 0);
    chk("rst_wr_en",      int'(tbl_wr_en), 0);
    chk("rst_wr_index",   int'(tbl_wr_index), 0);
    chk("rst_wr_weight",  int'(tbl_wr_weight), 0);
    chk("rst_init_done",  int'(init_done), 0);
    chk_en = 1;
    repeat (3) @(negedge clk);
    wlog.delete();
    rst_n = 1'b1;

    // Initialisation sweep
    wait_init();
    done_cyc = cyc;
    chk("init_write_count", wlog.size(), DEPTH);
    if (wlog.size() == DEPTH) begin
      ones = 0;
      foreach (wlog[i]) if (wlog[i].w == 1 && wlog[i].idx == i) ones++;
      chk("init_seq_weights", ones, DEPTH);
      chk("init_first_idx", wlog[0].idx, 0);
      chk("init_last_idx", wlog[DEPTH-1].idx, DEPTH - 1);
      chk("init_done_delay", done_cyc - wlog[DEPTH-1].cyc, 1);
    end

    // Single taken update, no fetch contention
    wlog.delete();
    push(5, 1);
    wait_writes(1, 50);
    if (wlog.size() >= 1) begin
      chk("single_idx", wlog[0].idx, 5);
      chk("single_w", wlog[0].w, 2);
      chk("single_latency", wlog[0].cyc - last_push_cyc, 4);
    end
    repeat (3) @(negedge clk);
    chk("single_one_pulse", wlog.size(), 1);

    // Saturation up and down
    wlog.delete();
    for (int i = 0; i < 3; i++) push(7, 1);
    wait_writes(3, 100);
    for (int i = 0; i < 3 && i < wlog.size(); i++) chk("sat_up_w", wlog[i].w, exp_sat7[i]);
    wlog.delete();
    for (int i = 0; i < 4; i++) push(9, 0);
    wait_writes(4, 100);
    for (int i = 0; i < 4 && i < wlog.size(); i++) chk("sat_dn_w", wlog[i].w, 0);

    // Starvation: fetch requests every cycle
    repeat (5) @(negedge clk);
    wlog.delete();
    pred_req = 1'b1;
    push(100, 1);
    wait_writes(1, 100);
    if (wlog.size() >= 1) begin
      chk("starve_latency", wlog[0].cyc - last_push_cyc, 12);
      chk("starve_w", wlog[0].w, 2);
    end

    // FIFO full under contention
    repeat (5) @(negedge clk);
    wlog.delete();
    sent = 0; saw_low = 0; guard = 0;
    @(negedge clk);
    while (sent < 6 && guard < 300) begin
      if (upd_ready) begin
        upd_valid = 1'b1; upd_index = 10'(200 + sent); upd_taken = 1'b1; sent++;
      end else begin
        upd_valid = 1'b0; saw_low = 1;
      end
      @(negedge clk);
      guard++;
    end
    upd_valid = 1'b0;
    chk("full_sent", sent, 6);
    chk("full_ready_dropped", int'(saw_low), 1);
    wait_writes(6, 400);
    for (int i = 0; i < 6 && i < wlog.size(); i++) begin
      chk("full_order_idx", wlog[i].idx, 200 + i);
      chk("full_order_w", wlog[i].w, 2);
    end
    pred_req = 1'b0;

    // Random traffic, small index range to provoke same-index hazards
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      pred_req   = ($urandom_range(0, 99) < 55);
      pred_index = 10'($urandom);
      upd_valid  = ($urandom_range(0, 99) < 40);
      upd_index  = 10'($urandom_range(0, 15));
      upd_taken  = 1'($urandom);
    end
    @(negedge clk);
    upd_valid = 1'b0; pred_req = 1'b0;
    repeat (200) @(negedge clk);
    for (int i = 0; i < 16; i++) chk("table_vs_model", int'(tbl_mem[i]), m_mem[i]);

    // Reset while the update's read is in flight
    wlog.delete();
    push(300, 1);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_upd_ready",  int'(upd_ready), 0);
    chk("midrst_pred_stall", int'(pred_stall), 1);
    chk("midrst_tbl_index",  int'(tbl_index), 0);
    chk("midrst_wr_en",      int'(tbl_wr_en), 0);
    chk("midrst_init_done",  int'(init_done), 0);
    repeat (3) @(negedge clk);
    chk("midrst_no_write", wlog.size(), 0);
    chk("midrst_entry_untouched", int'(tbl_mem[300]), 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("resweep_wr_en", int'(tbl_wr_en), 1);
    chk("resweep_idx0", int'(tbl_wr_index), 0);
    wait_init();
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
